async_fifo_level: RTL
=====================

Name: async_fifo_level

Overview:
Dual-clock gray-pointer FIFO. Successor to the basic Cummings-style async FIFO, with four additions:
- configurable synchronizer depth;
- per-domain fill levels;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags with clear inputs.

It sits between the AXI4 stream and bus blocks at clock-domain crossings, and feeds credit and backpressure logic from the level outputs.

Parameters:
W, 8, data width in bits
ASIZE, 4, address bits; DEPTH = 2**ASIZE entries
SYNC_STAGES, 2, flops per pointer synchronizer chain; legal range 2..4
AF_THRESH, 12, wr_almost_full asserts when wr_level >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, rd_almost_empty asserts when rd_level <= AE_THRESH; legal range 0..DEPTH-1

Ports:
wclk  in  1  write clock
wrst_n  in  1  write-domain reset, asynchronous, active-low
rclk  in  1  read clock
rrst_n  in  1  read-domain reset, asynchronous, active-low
wr_data  in  W  write data
wr_en  in  1  write request
wr_full  out  1  FIFO full (write domain)
wr_almost_full  out  1  level at or above AF_THRESH
wr_level  out  ASIZE+1  write-side occupancy, conservative (may over-report)
wr_overflow  out  1  sticky: wr_en was seen while wr_full
wr_ovf_clr  in  1  clears wr_overflow
rd_en  in  1  read request / pop
rd_data  out  W  head-of-FIFO data (first-word fall-through)
rd_empty  out  1  FIFO empty (read domain)
rd_almost_empty  out  1  level at or below AE_THRESH
rd_level  out  ASIZE+1  read-side occupancy, conservative (may under-report)
rd_underflow  out  1  sticky: rd_en was seen while rd_empty
rd_unf_clr  in  1  clears rd_underflow

Behaviour:
- Pointers: binary plus gray registers, each ASIZE+1 bits.
  - wbin increments by (wr_en & ~wr_full); rbin increments by (rd_en & ~rd_empty).
  - Gray code = b ^ (b>>1).
  - Only gray pointers cross domains, each through SYNC_STAGES flops reset by the destination-domain reset.
- Memory:
  - Written at posedge wclk when wr_en & ~wr_full.
  - rd_data = mem[rbin[ASIZE-1:0]], asynchronous read.
  - rd_data is valid whenever rd_empty = 0; its value is don't-care when empty.
- Flags and levels are registered from next-state pointers, so they are correct in the same cycle as the push or pop that changes them:
  - wr_level = wbin_next - gray2bin(wq_rptr), mod 2**(ASIZE+1).
  - wr_full = (wr_level_next == DEPTH); equivalent to the gray test with the top two bits inverted.
  - wr_almost_full = (wr_level_next >= AF_THRESH).
  - rd_level = gray2bin(rq_wptr) - rbin_next.
  - rd_empty = (rd_level_next == 0).
  - rd_almost_empty = (rd_level_next <= AE_THRESH).
- Latency:
  - A push at wclk edge N makes rd_empty fall after SYNC_STAGES+1 rclk edges.
  - A pop frees a slot, and wr_full falls, after SYNC_STAGES+1 wclk edges.
- Illegal operations:
  - Write while full: data dropped, pointers unchanged, wr_overflow set on the next wclk edge.
  - Read while empty: pointers unchanged, rd_underflow set.
- Sticky flags:
  - Hold until their clear input is sampled high.
  - If set and clear happen in the same cycle, set wins.
- Simultaneous push and pop in a domain: the level is unchanged on that domain's side, and each flag updates correctly.
- Wrap-around: pointers wrap at 2**(ASIZE+1). The extra MSB disambiguates full from empty.
- Reset values:
  - Write domain: wr_full = 0, wr_almost_full = 0, wr_level = 0, wr_overflow = 0.
  - Read domain: rd_empty = 1, rd_almost_empty = 1, rd_level = 0, rd_underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation: resetting a single domain is unsupported. Both resets must overlap, with each asserted for at least SYNC_STAGES+1 cycles of its own clock. After that the FIFO is empty.
- Simulation-only checks: assertion on AF_THRESH/AE_THRESH range and on SYNC_STAGES range at elaboration.

Decomposition:
- Package async_fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width via a parameterised class static function or a fixed-maximum-width function with slicing;
  - localparam limits MIN_SYNC = 2, MAX_SYNC = 4.
- Sub-module async_fifo_sync: N-stage, WIDTH-bit synchronizer with asynchronous active-low reset. Instantiated twice, once for wptr into rclk and once for rptr into wclk.
- Top block: contains the write-pointer/full logic, the read-pointer/empty logic and the memory array.

Test Plan (W = 8, ASIZE = 4, SYNC_STAGES = 2, AF = 12, AE = 2; wclk 10 ns, rclk 17 ns):
- Reset release, then 16 writes of values 0x00..0x0F:
  - wr_full rises on the edge of the 16th write;
  - wr_almost_full rises on the 12th write;
  - wr_level reads 16.
- Read side of the same test:
  - rd_empty falls 3 rclk edges after the first write;
  - drain returns 0x00..0x0F in order;
  - rd_empty rises on the pop of the final word;
  - rd_almost_empty is 1 while rd_level <= 2.
- 17th write while full:
  - wr_overflow becomes 1 and stays 1 until wr_ovf_clr;
  - the read-back sequence is unchanged, with no 0x10 present.
- rd_en while empty just after reset:
  - rd_underflow becomes 1;
  - rd_level stays 0, and the next written word is still read first.
- Continuous random push/pop for 10k cycles, both clock ratios (rclk faster and slower):
  - scoreboard matches every word;
  - wr_level >= true occupancy >= rd_level at all times;
  - pointers wrap at least 50 times.
- Both resets asserted mid-stream with 5 words queued:
  - after release rd_empty = 1 and wr_level = 0;
  - the first subsequent write 0xA5 is the first word read.

Source files
------------

// File: rtl/async_fifo_level_pkg.sv
// async_fifo_pkg: gray-code helpers and synchronizer depth limits shared by the async FIFO slice.
package async_fifo_pkg;
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 4;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/async_fifo_level_if.sv
// async_fifo_level_if: write- and read-side handshake, level and error signals of the async FIFO.
interface async_fifo_level_if #(
  parameter int W     = 8,
  parameter int ASIZE = 4
);
  logic [W-1:0]   wr_data;
  logic           wr_en;
  logic           wr_full;
  logic           wr_almost_full;
  logic [ASIZE:0] wr_level;
  logic           wr_overflow;
  logic           wr_ovf_clr;
  logic           rd_en;
  logic [W-1:0]   rd_data;
  logic           rd_empty;
  logic           rd_almost_empty;
  logic [ASIZE:0] rd_level;
  logic           rd_underflow;
  logic           rd_unf_clr;
  modport master (
    output wr_data, wr_en, wr_ovf_clr, rd_en, rd_unf_clr,
    input  wr_full, wr_almost_full, wr_level, wr_overflow,
    input  rd_data, rd_empty, rd_almost_empty, rd_level, rd_underflow
  );
  modport slave (
    input  wr_data, wr_en, wr_ovf_clr, rd_en, rd_unf_clr,
    output wr_full, wr_almost_full, wr_level, wr_overflow,
    output rd_data, rd_empty, rd_almost_empty, rd_level, rd_underflow
  );
endinterface

// File: rtl/async_fifo_level_sync.sv
// async_fifo_sync: N-flop synchronizer chain for a gray pointer, async active-low reset.
module async_fifo_sync #(
  parameter int N     = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [N-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[N-2:0], d_i};
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/async_fifo_level.sv
// async_fifo_level: dual-clock gray-pointer FIFO with per-domain levels, almost flags and sticky errors.
module async_fifo_level
  import async_fifo_pkg::*;
#(
  parameter int W           = 8,
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 2
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic rclk,
  input  logic rrst_n,
  async_fifo_level_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(AF_THRESH);
  localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(AE_THRESH);

  if (SYNC_STAGES < MIN_SYNC || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
    $error("async_fifo_level: SYNC_STAGES out of range 2..4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("async_fifo_level: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("async_fifo_level: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [W-1:0] mem [DEPTH];

  logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d, wq_rgray;
  logic           wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d, push;
  logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d, rq_wgray;
  logic           rempty_q, rempty_d, rae_q, rae_d, runf_q, runf_d, pop;

  async_fifo_sync #(.N(SYNC_STAGES), .WIDTH(ASIZE+1)) u_sync_w2r (
    .clk(rclk), .rst_n(rrst_n), .d_i(wgray_q), .q_o(rq_wgray)
  );
  async_fifo_sync #(.N(SYNC_STAGES), .WIDTH(ASIZE+1)) u_sync_r2w (
    .clk(wclk), .rst_n(wrst_n), .d_i(rgray_q), .q_o(wq_rgray)
  );

  // Flags come from next-state pointers so they track a push in the same cycle.
  assign push = bus.wr_en & ~wfull_q;
  always_comb begin
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, push};
    wgray_d  = (ASIZE+1)'(bin2gray(32'(wbin_d)));
    wlevel_d = wbin_d - (ASIZE+1)'(gray2bin(32'(wq_rgray)));
    wfull_d  = wlevel_d == DEPTH_L;
    waf_d    = wlevel_d >= AF_L;
    wovf_d   = (bus.wr_en & wfull_q) | (wovf_q & ~bus.wr_ovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end

  always_ff @(posedge wclk)
    if (push) mem[wbin_q[ASIZE-1:0]] <= bus.wr_data;

  assign pop = bus.rd_en & ~rempty_q;
  always_comb begin
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, pop};
    rgray_d  = (ASIZE+1)'(bin2gray(32'(rbin_d)));
    rlevel_d = (ASIZE+1)'(gray2bin(32'(rq_wgray))) - rbin_d;
    rempty_d = rlevel_d == '0;
    rae_d    = rlevel_d <= AE_L;
    runf_d   = (bus.rd_en & rempty_q) | (runf_q & ~bus.rd_unf_clr);
  end

  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      runf_q   <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      runf_q   <= runf_d;
    end

  assign bus.wr_full         = wfull_q;
  assign bus.wr_almost_full  = waf_q;
  assign bus.wr_level        = wlevel_q;
  assign bus.wr_overflow     = wovf_q;
  assign bus.rd_data         = mem[rbin_q[ASIZE-1:0]];
  assign bus.rd_empty        = rempty_q;
  assign bus.rd_almost_empty = rae_q;
  assign bus.rd_level        = rlevel_q;
  assign bus.rd_underflow    = runf_q;
endmodule
